// File: rtl/snake_pkg.sv
// Shared types, reset constants and helpers for the snake step controller.
package snake_pkg;

  localparam int GRID_W_DEF = 16;
  localparam int GRID_H_DEF = 16;

  // Up decreases y and down increases y (row 0 is the top of the screen).
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] x;
  } cell_t;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_TAIL   = 3'd4,
    ST_SPAWN  = 3'd5,
    ST_OVER   = 3'd6,
    ST_WIN    = 3'd7
  } state_t;

  localparam cell_t START_HEAD  = '{y: 4'd8, x: 4'd8};
  localparam cell_t RESET_FRUIT = '{y: 4'd8, x: 4'd12};

  function automatic logic is_opposite(dir_t a, dir_t b);
    return (2'(a) ^ 2'(b)) == 2'd2;
  endfunction

  // Body segment idx (0 = head) of the starting snake lying along row 8.
  function automatic cell_t init_body(int idx);
    cell_t c;
    c.y = START_HEAD.y;
    c.x = START_HEAD.x - 4'(idx);
    return c;
  endfunction

  function automatic logic [255:0] init_occ(int len);
    logic [255:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < len) m[8'(init_body(i))] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/snake_body_ram.sv
// Circular body store: one write port and one registered read port, no reset so it maps to block RAM.
module snake_body_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/snake_step_controller.sv
// Snake game sequencer: one move per step_tick, then fruit spawning, over a body ring and occupancy bitmap.
// Define SNAKE_WRAP_EN to wrap moves at the grid edges instead of ending the game there.
//
// state  | meaning
// INIT   | write the starting body into the ring, one entry per cycle
// IDLE   | wait for step_tick, latch direction and next head cell
// CHECK  | border / self-collision / fruit test on the next head cell
// COMMIT | push new head, update occupancy, start tail read or grow
// TAIL   | capture the new tail from the ring read
// SPAWN  | random fruit tries, then linear search for a free cell
// OVER   | game over, everything frozen
// WIN    | board full, everything frozen
module snake_step_controller
  import snake_pkg::*;
#(
  parameter int GRID_W      = GRID_W_DEF,
  parameter int GRID_H      = GRID_H_DEF,
  parameter int MAX_LEN     = 256,
  parameter int INIT_LEN    = 4,
  parameter int SPAWN_TRIES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         restart,
  input  logic         step_tick,
  input  logic [1:0]   dir_req,
  input  logic [7:0]   rand_val,
  output logic [255:0] occ_map,
  output logic [3:0]   head_x,
  output logic [3:0]   head_y,
  output logic [3:0]   tail_x,
  output logic [3:0]   tail_y,
  output logic [3:0]   fruit_x,
  output logic [3:0]   fruit_y,
  output logic         fruit_valid,
  output logic [8:0]   length,
  output logic         game_over,
  output logic         win,
  output logic         busy,
  output logic         step_dropped
);

  localparam int PTR_W = $clog2(MAX_LEN);
  localparam int TRY_W = $clog2(SPAWN_TRIES + 1);

  state_t           state, state_nx;
  logic [255:0]     occ, occ_d;
  cell_t            head, head_d, tail, tail_d, fruit, fruit_d;
  cell_t            next_cell, next_d, lin_idx, lin_idx_d, probe;
  logic             fruit_valid_r, fruit_valid_d;
  logic [8:0]       length_r, length_d;
  logic [PTR_W-1:0] head_ptr, head_ptr_d;
  dir_t             dir_cur, dir_cur_d, dir_use, dir_use_d, dir_sel;
  logic             border_r, border_d, grow_r, grow_d;
  logic [2:0]       init_cnt, init_cnt_d;
  logic [TRY_W-1:0] try_cnt, try_cnt_d;
  logic [7:0]       lin_cnt, lin_cnt_d;
  logic             search_lin, search_lin_d;
  logic             game_over_d, win_d, step_dropped_d;
  logic             busy_st, grow_now, hit_now;

  logic             we, rd_en;
  logic [PTR_W-1:0] wr_addr, rd_addr;
  logic [7:0]       wr_data, rd_data;

  logic [4:0]       nx5, ny5;
  cell_t            mv_cell;
  logic             mv_border;

  snake_body_ram #(.DEPTH(MAX_LEN), .AW(PTR_W)) u_body_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign dir_sel = is_opposite(dir_t'(dir_req), dir_cur) ? dir_cur : dir_t'(dir_req);
  assign busy_st = !(state inside {ST_IDLE, ST_OVER, ST_WIN});

  // Next head cell with one spare bit so an off-grid move is visible as >= grid size.
  always_comb begin
    nx5 = {1'b0, head.x};
    ny5 = {1'b0, head.y};
    case (dir_sel)
      DIR_UP:    ny5 = ny5 - 5'd1;
      DIR_RIGHT: nx5 = nx5 + 5'd1;
      DIR_DOWN:  ny5 = ny5 + 5'd1;
      default:   nx5 = nx5 - 5'd1;
    endcase
`ifdef SNAKE_WRAP_EN
    mv_cell.x = 4'(nx5 & 5'(GRID_W - 1));
    mv_cell.y = 4'(ny5 & 5'(GRID_H - 1));
    mv_border = 1'b0;
`else
    mv_cell.x = nx5[3:0];
    mv_cell.y = ny5[3:0];
    mv_border = (nx5 >= 5'(GRID_W)) || (ny5 >= 5'(GRID_H));
`endif
  end

  // The tail cell is vacated by this same move unless the snake grows.
  assign grow_now = fruit_valid_r && (next_cell == fruit);
  assign hit_now  = occ[8'(next_cell)] && !((next_cell == tail) && !grow_now);
  assign probe    = search_lin ? lin_idx : cell_t'(rand_val);

  always_comb begin
    state_nx       = state;
    occ_d          = occ;
    head_d         = head;
    tail_d         = tail;
    fruit_d        = fruit;
    fruit_valid_d  = fruit_valid_r;
    length_d       = length_r;
    head_ptr_d     = head_ptr;
    dir_cur_d      = dir_cur;
    dir_use_d      = dir_use;
    next_d         = next_cell;
    border_d       = border_r;
    grow_d         = grow_r;
    init_cnt_d     = init_cnt;
    try_cnt_d      = try_cnt;
    lin_cnt_d      = lin_cnt;
    lin_idx_d      = lin_idx;
    search_lin_d   = search_lin;
    game_over_d    = game_over;
    win_d          = win;
    step_dropped_d = step_tick && busy_st;
    we             = 1'b0;
    wr_addr        = head_ptr;
    wr_data        = 8'(next_cell);
    rd_en          = 1'b0;
    rd_addr        = '0;

    if (restart) begin
      state_nx       = ST_INIT;
      occ_d          = init_occ(INIT_LEN);
      head_d         = START_HEAD;
      tail_d         = init_body(INIT_LEN - 1);
      fruit_valid_d  = 1'b0;
      length_d       = 9'(INIT_LEN);
      head_ptr_d     = PTR_W'(INIT_LEN - 1);
      dir_cur_d      = DIR_RIGHT;
      dir_use_d      = DIR_RIGHT;
      init_cnt_d     = 3'(INIT_LEN - 1);
      try_cnt_d      = TRY_W'(SPAWN_TRIES);
      search_lin_d   = 1'b0;
      game_over_d    = 1'b0;
      win_d          = 1'b0;
      step_dropped_d = 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          // Ring entry k holds body segment INIT_LEN-1-k, i.e. the tail sits at entry 0.
          we      = 1'b1;
          wr_addr = PTR_W'(INIT_LEN - 1) - PTR_W'(init_cnt);
          wr_data = 8'(init_body(int'(init_cnt)));
          if (init_cnt == 3'd0) begin
            state_nx     = fruit_valid_r ? ST_IDLE : ST_SPAWN;
            try_cnt_d    = TRY_W'(SPAWN_TRIES);
            search_lin_d = 1'b0;
          end else begin
            init_cnt_d = init_cnt - 3'd1;
          end
        end
        ST_IDLE: begin
          if (step_tick) begin
            dir_use_d = dir_sel;
            next_d    = mv_cell;
            border_d  = mv_border;
            state_nx  = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (border_r || hit_now) begin
            game_over_d = 1'b1;
            state_nx    = ST_OVER;
          end else begin
            grow_d   = grow_now;
            state_nx = ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          head_ptr_d = head_ptr + PTR_W'(1);
          we         = 1'b1;
          wr_addr    = head_ptr + PTR_W'(1);
          head_d     = next_cell;
          dir_cur_d  = dir_use;
          if (!grow_r) begin
            occ_d[8'(tail)] = 1'b0;
            rd_en           = 1'b1;
            rd_addr         = head_ptr + PTR_W'(2) - length_r[PTR_W-1:0];
            state_nx        = ST_TAIL;
          end else begin
            length_d      = length_r + 9'd1;
            fruit_valid_d = 1'b0;
            try_cnt_d     = TRY_W'(SPAWN_TRIES);
            search_lin_d  = 1'b0;
            if (length_r + 9'd1 == 9'(MAX_LEN)) begin
              win_d    = 1'b1;
              state_nx = ST_WIN;
            end else begin
              state_nx = ST_SPAWN;
            end
          end
          occ_d[8'(next_cell)] = 1'b1;
        end
        ST_TAIL: begin
          tail_d   = cell_t'(rd_data);
          state_nx = ST_IDLE;
        end
        ST_SPAWN: begin
          if (!occ[8'(probe)]) begin
            fruit_d       = probe;
            fruit_valid_d = 1'b1;
            state_nx      = ST_IDLE;
          end else if (!search_lin) begin
            if (try_cnt == TRY_W'(1)) begin
              search_lin_d = 1'b1;
              lin_idx_d    = cell_t'(8'(probe) + 8'd1);
              lin_cnt_d    = 8'd255;
            end else begin
              try_cnt_d = try_cnt - TRY_W'(1);
            end
          end else if (lin_cnt == 8'd1) begin
            // No free cell anywhere: carry on without a fruit.
            state_nx = ST_IDLE;
          end else begin
            lin_cnt_d = lin_cnt - 8'd1;
            lin_idx_d = cell_t'(8'(lin_idx) + 8'd1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_INIT;
      occ           <= init_occ(INIT_LEN);
      head          <= START_HEAD;
      tail          <= init_body(INIT_LEN - 1);
      fruit         <= RESET_FRUIT;
      fruit_valid_r <= 1'b1;
      length_r      <= 9'(INIT_LEN);
      head_ptr      <= PTR_W'(INIT_LEN - 1);
      dir_cur       <= DIR_RIGHT;
      dir_use       <= DIR_RIGHT;
      next_cell     <= START_HEAD;
      border_r      <= 1'b0;
      grow_r        <= 1'b0;
      init_cnt      <= 3'(INIT_LEN - 1);
      try_cnt       <= TRY_W'(SPAWN_TRIES);
      lin_cnt       <= '0;
      lin_idx       <= '0;
      search_lin    <= 1'b0;
      game_over     <= 1'b0;
      win           <= 1'b0;
      step_dropped  <= 1'b0;
    end else begin
      state         <= state_nx;
      occ           <= occ_d;
      head          <= head_d;
      tail          <= tail_d;
      fruit         <= fruit_d;
      fruit_valid_r <= fruit_valid_d;
      length_r      <= length_d;
      head_ptr      <= head_ptr_d;
      dir_cur       <= dir_cur_d;
      dir_use       <= dir_use_d;
      next_cell     <= next_d;
      border_r      <= border_d;
      grow_r        <= grow_d;
      init_cnt      <= init_cnt_d;
      try_cnt       <= try_cnt_d;
      lin_cnt       <= lin_cnt_d;
      lin_idx       <= lin_idx_d;
      search_lin    <= search_lin_d;
      game_over     <= game_over_d;
      win           <= win_d;
      step_dropped  <= step_dropped_d;
    end
  end

  assign occ_map     = occ;
  assign head_x      = head.x;
  assign head_y      = head.y;
  assign tail_x      = tail.x;
  assign tail_y      = tail.y;
  assign fruit_x     = fruit.x;
  assign fruit_y     = fruit.y;
  assign fruit_valid = fruit_valid_r;
  assign length      = length_r;
  assign busy        = busy_st;

endmodule
